// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package hazard_pkg;

    // Memory-side FSM: normal flow, waiting on a slow access, timed out.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/hazard_cmp.sv
// One ID-stage source operand compared against the EXE and MEM destinations.
// With forwarding on, only a load in EXE can't be bypassed (load-use).
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       check_en_i,
    input  logic [4:0] exe_dest_i,
    input  logic       exe_wb_en_i,
    input  logic       exe_mem_r_en_i,
    input  logic [4:0] mem_dest_i,
    input  logic       mem_wb_en_i,
    input  logic       fwd_en_i,
    output logic       hazard_o
);

    logic exe_match;
    logic mem_match;

    assign exe_match = (src_i == exe_dest_i) && exe_wb_en_i;
    assign mem_match = (src_i == mem_dest_i) && mem_wb_en_i;

    // Register 0 never carries a dependency.
    always_comb begin
        hazard_o = 1'b0;
        if (check_en_i && (src_i != 5'd0)) begin
            if (fwd_en_i) hazard_o = exe_match && exe_mem_r_en_i;
            else          hazard_o = exe_match || mem_match;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW bubbles, branch flushes, memory-busy freezes
// with a timeout error state, and stall/flush performance counters.
// Priority of pipeline controls: memory freeze > branch flush > hazard bubble.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_rw_en,
    input  logic             mem_ready,
    input  logic             br_taken,
    input  logic             fwd_en,
    output logic             freeze_front,
    output logic             freeze_all,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_e           state_dbg
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_busy;
    logic               haz1, haz2, hazard;

    hazard_cmp u_cmp_src1 (
        .src_i          (id_src1),
        .check_en_i     (1'b1),
        .exe_dest_i     (exe_dest),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_r_en_i (exe_mem_r_en),
        .mem_dest_i     (mem_dest),
        .mem_wb_en_i    (mem_wb_en),
        .fwd_en_i       (fwd_en),
        .hazard_o       (haz1)
    );

    hazard_cmp u_cmp_src2 (
        .src_i          (id_src2),
        .check_en_i     (id_two_src),
        .exe_dest_i     (exe_dest),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_r_en_i (exe_mem_r_en),
        .mem_dest_i     (mem_dest),
        .mem_wb_en_i    (mem_wb_en),
        .fwd_en_i       (fwd_en),
        .hazard_o       (haz2)
    );

    assign hazard   = haz1 | haz2;
    assign mem_busy = mem_rw_en & ~mem_ready;
    assign wait_inc = wait_q + WAIT_W'(1);

    // Next state: count consecutive busy cycles, trap in ERROR on timeout.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    wait_d  = wait_inc;
                    state_d = (wait_inc >= WAIT_W'(MEM_TIMEOUT)) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Pipeline controls, all forced low while reset is held.
    always_comb begin
        freeze_all   = 1'b0;
        freeze_front = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (!rst) begin
            if (mem_busy || (state_q == ST_ERROR)) begin
                freeze_all   = 1'b1;
                freeze_front = 1'b1;
            end else if (br_taken) begin
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end else if (hazard) begin
                freeze_front = 1'b1;
                flush_id_exe = 1'b1;
            end
        end
    end

    // Counter next values; both wrap naturally at CNT_W bits.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(freeze_front);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_if_id);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = (state_q == ST_ERROR);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// each cycle compared against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
  logic          id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic          mem_rw_en, mem_ready, br_taken, fwd_en;
  logic          freeze_front, freeze_all, flush_if_id, flush_id_exe, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  state_e        state_dbg;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_rw_en    (mem_rw_en),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .fwd_en       (fwd_en),
    .freeze_front (freeze_front),
    .freeze_all   (freeze_all),
    .flush_if_id  (flush_if_id),
    .flush_id_exe (flush_id_exe),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  bit m_err;     // timed out, sticky until reset
  int m_busy;    // consecutive busy cycles seen
  int m_stall;
  int m_flush;

  function automatic bit src_hazard(logic [4:0] s, bit en);
    bit exe_hit, mem_hit;
    exe_hit = (s == exe_dest) && exe_wb_en;
    mem_hit = (s == mem_dest) && mem_wb_en;
    if (!en || s == 5'd0) return 1'b0;
    if (fwd_en) return exe_hit && exe_mem_r_en;
    return exe_hit || mem_hit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare current outputs with the model, then advance it.
  task automatic step();
    bit busy, haz, bub, e_fa, e_ff, e_fi, e_fe;
    @(negedge clk);
    busy = mem_rw_en && !mem_ready;
    haz  = src_hazard(id_src1, 1'b1) || src_hazard(id_src2, id_two_src);
    e_fa = !rst && (busy || m_err);
    e_fi = !rst && !e_fa && br_taken;
    bub  = !rst && !e_fa && !br_taken && haz;
    e_ff = e_fa || bub;
    e_fe = e_fi || bub;
    chk("freeze_all",   32'(freeze_all),   32'(e_fa));
    chk("freeze_front", 32'(freeze_front), 32'(e_ff));
    chk("flush_if_id",  32'(flush_if_id),  32'(e_fi));
    chk("flush_id_exe", 32'(flush_id_exe), 32'(e_fe));
    chk("mem_err",      32'(mem_err),      32'(m_err));
    chk("stall_cnt",    32'(stall_cnt),    32'(m_stall));
    chk("flush_cnt",    32'(flush_cnt),    32'(m_flush));
    @(posedge clk);
    if (rst) begin
      m_err = 1'b0; m_busy = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall = (m_stall + int'(e_ff)) % (1 << CW);
      m_flush = (m_flush + int'(e_fi)) % (1 << CW);
      if (!m_err) begin
        if (busy) begin
          m_busy++;
          if (m_busy >= TO) m_err = 1'b1;
        end else begin
          m_busy = 0;
        end
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
    exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 5'd0; mem_wb_en = 1'b0;
    mem_rw_en = 1'b0; mem_ready = 1'b0; br_taken = 1'b0; fwd_en = 1'b0;
  endtask

  task automatic raw_exe(input logic [4:0] r);
    id_src1 = r; exe_dest = r; exe_wb_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    m_err = 1'b0; m_busy = 0; m_stall = 0; m_flush = 0;

    // Controls stay low during reset even with branch and hazard present.
    br_taken = 1'b1; raw_exe(5'd5);
    step();
    rst = 1'b0;
    idle();
    step();

    // Plain RAW on EXE result without forwarding.
    raw_exe(5'd5);
    step();
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd1);
    // RAW on MEM result without forwarding, then with forwarding (none).
    idle(); id_src1 = 5'd3; mem_dest = 5'd3; mem_wb_en = 1'b1;
    step();
    fwd_en = 1'b1;
    step();

    // Load-use on src2, then non-load, then src2 ignored, then r0.
    idle(); fwd_en = 1'b1;
    id_src2 = 5'd7; id_two_src = 1'b1; exe_dest = 5'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    step();
    exe_mem_r_en = 1'b0;
    step();
    exe_mem_r_en = 1'b1; id_two_src = 1'b0;
    step();
    idle(); fwd_en = 1'b1; exe_dest = 5'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    step();

    // Branch beats a simultaneous load-use hazard.
    idle(); fwd_en = 1'b1; raw_exe(5'd9); exe_mem_r_en = 1'b1; br_taken = 1'b1;
    step();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Memory busy for three cycles with a taken branch, then ready.
    idle(); mem_rw_en = 1'b1; br_taken = 1'b1;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    idle();
    step();

    // Busy long enough to time out; error is sticky, cleared by reset.
    mem_rw_en = 1'b1;
    repeat (6) step();
    mem_ready = 1'b1;
    step();
    chk("err_sticky", 32'(mem_err), 32'd1);
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_stall",   32'(stall_cnt), 32'd0);
    chk("rst_flush",   32'(flush_cnt), 32'd0);
    step();

    // Stall counter wrap at CW bits.
    raw_exe(5'd5);
    repeat (15) step();
    chk("stall_pre_wrap", 32'(stall_cnt), 32'd15);
    step();
    chk("stall_wrap", 32'(stall_cnt), 32'd0);

    // Random traffic over a small register space to provoke matches.
    idle();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      mem_rw_en    = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      br_taken     = ($urandom_range(0, 4) == 0);
      fwd_en       = 1'($urandom_range(0, 1));
      step();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
